// File: rtl/rr_sched_pkg.sv
// rr_sched_pkg: shared state encoding, idle index code and default sizing for the round-robin scheduler
package rr_sched_pkg;
   typedef enum logic {IDLE, GRANT} state_e;
   localparam int N_DEF = 16;
   localparam int IDX_W_DEF = 8;
   localparam int MAX_HOLD_DEF = 12;
   localparam int CNT_W_DEF = 4;
   localparam logic [7:0] IDLE_CODE = 8'hF0;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority pick, highest set request below ptr first, else highest set request overall
module rr_pick #(
   parameter int N = 16,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic          any_o,
   output logic [PW-1:0] win_o
);
   logic [N-1:0] masked;
   logic [PW-1:0] lo_idx, hi_idx;
   assign masked = req_i & ((N'(1) << ptr_i) - N'(1));
   always_comb begin
      lo_idx = '0;
      hi_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (masked[i]) lo_idx = PW'(i);
         if (req_i[i]) hi_idx = PW'(i);
      end
   end
   assign any_o = |req_i;
   assign win_o = |masked ? lo_idx : hi_idx;
endmodule

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin grant of one resource among N requesters with hold, timeout and enable gate
module rr_grant_scheduler #(
   parameter int N = rr_sched_pkg::N_DEF,
   parameter int IDX_W = rr_sched_pkg::IDX_W_DEF,
   parameter logic [IDX_W-1:0] IDLE_CODE = IDX_W'(rr_sched_pkg::IDLE_CODE),
   parameter int MAX_HOLD = rr_sched_pkg::MAX_HOLD_DEF,
   parameter int CNT_W = rr_sched_pkg::CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [N-1:0]     req_i,
   input  logic             release_i,
   output logic             gnt_valid_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic [N-1:0]     gnt_onehot_o,
   output logic             timeout_o,
   output logic             busy_o
);
   import rr_sched_pkg::*;
   localparam int PW = $clog2(N);
   localparam logic [CNT_W-1:0] SAT = MAX_HOLD == 0 ? '1 : CNT_W'(MAX_HOLD);
   state_e state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d, win;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N-1:0] oh_q, oh_d;
   logic to_q, to_d, any, hit_max, keep;
   rr_pick #(.N(N), .PW(PW)) u_pick (
      .req_i(req_i),
      .ptr_i(ptr_q),
      .any_o(any),
      .win_o(win)
   );
   assign hit_max = MAX_HOLD != 0 && cnt_q == CNT_W'(MAX_HOLD);
   // ptr_q doubles as the current holder's index while in GRANT
   assign keep = req_i[ptr_q] && !release_i;
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      idx_d = idx_q;
      oh_d = oh_q;
      to_d = 1'b0;
      if (state_q == IDLE) begin
         if (en_i && any) begin
            state_d = GRANT;
            ptr_d = win;
            cnt_d = CNT_W'(1);
            idx_d = IDX_W'(win);
            oh_d = N'(1) << win;
         end
      end else if (!keep || hit_max) begin
         state_d = IDLE;
         cnt_d = '0;
         idx_d = IDLE_CODE;
         oh_d = '0;
         to_d = keep;
      end else begin
         cnt_d = cnt_q != SAT ? cnt_q + CNT_W'(1) : cnt_q;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q <= '0;
         cnt_q <= '0;
         idx_q <= IDLE_CODE;
         oh_q <= '0;
         to_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         oh_q <= oh_d;
         to_q <= to_d;
      end
   end
   assign gnt_valid_o = state_q == GRANT;
   assign busy_o = state_q == GRANT;
   assign gnt_idx_o = idx_q;
   assign gnt_onehot_o = oh_q;
   assign timeout_o = to_q;
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb_rr_grant_scheduler: directed plan plus random traffic, scoreboarded against a cycle-level reference model
module tb_rr_grant_scheduler;
   localparam int N = 16;
   localparam int MAX_HOLD = 12;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic [N-1:0] req = '0;
   logic rel = 1'b0;
   logic gnt_valid, timeout, busy;
   logic [7:0] gnt_idx;
   logic [N-1:0] gnt_onehot;
   int checks = 0;
   int errors = 0;
   typedef struct {
      bit v;
      logic [7:0] idx;
      logic [N-1:0] oh;
      bit to;
      bit busy;
   } exp_t;
   exp_t sb_q[$];
   bit m_held = 0;
   int m_ptr = 0;
   int m_cnt = 0;
   bit m_to = 0;

   rr_grant_scheduler dut (
      .clk(clk),
      .rst(rst),
      .en_i(en),
      .req_i(req),
      .release_i(rel),
      .gnt_valid_o(gnt_valid),
      .gnt_idx_o(gnt_idx),
      .gnt_onehot_o(gnt_onehot),
      .timeout_o(timeout),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: search order is ptr-1, ptr-2, ... modulo N; holder is remembered in m_ptr
   always @(posedge clk) begin
      exp_t e;
      bit found;
      m_to = 0;
      if (rst) begin
         m_held = 0;
         m_ptr = 0;
         m_cnt = 0;
      end else if (!m_held) begin
         if (en && req != 0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
               if (!found && req[(m_ptr - k + N) % N]) begin
                  found = 1;
                  m_ptr = (m_ptr - k + N) % N;
               end
            end
            m_held = 1;
            m_cnt = 1;
         end
      end else if (rel || !req[m_ptr]) begin
         m_held = 0;
      end else if (m_cnt == MAX_HOLD) begin
         m_held = 0;
         m_to = 1;
      end else begin
         m_cnt++;
      end
      e.v = m_held;
      e.idx = m_held ? 8'(m_ptr) : 8'hF0;
      e.oh = m_held ? N'(1) << m_ptr : '0;
      e.to = m_to;
      e.busy = m_held;
      sb_q.push_back(e);
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_empty at %0t: got 0 entries expected 1", $time);
      end else begin
         e = sb_q.pop_front();
         check("sb_gnt_valid", 32'(gnt_valid), 32'(e.v));
         check("sb_gnt_idx", 32'(gnt_idx), 32'(e.idx));
         check("sb_gnt_onehot", 32'(gnt_onehot), 32'(e.oh));
         check("sb_timeout", 32'(timeout), 32'(e.to));
         check("sb_busy", 32'(busy), 32'(e.busy));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      cyc(2);
      check("rst_valid", 32'(gnt_valid), 0);
      check("rst_idx", 32'(gnt_idx), 32'h0F0);
      check("rst_onehot", 32'(gnt_onehot), 0);
      check("rst_busy", 32'(busy), 0);
      rst = 0;
      en = 1;
      req = 16'h8001;
      cyc(1);
      check("hip_idx", 32'(gnt_idx), 15);
      check("hip_onehot", 32'(gnt_onehot), 32'h8000);
      req = 16'h0001;
      cyc(1);
      check("drop_idle_idx", 32'(gnt_idx), 32'h0F0);
      cyc(1);
      check("after_drop_idx", 32'(gnt_idx), 0);
      req = 0;
      cyc(1);
      req = 16'hFFFF;
      cyc(1);
      for (int k = 0; k <= N; k++) begin
         check("rot_idx", 32'(gnt_idx), 32'((15 - k + N) % N));
         rel = 1;
         cyc(1);
         rel = 0;
         if (k == N) req = 0;
         check("rot_bubble", 32'(gnt_valid), 0);
         cyc(1);
      end
      req = 16'h0020;
      cyc(1);
      for (int i = 0; i < MAX_HOLD; i++) begin
         check("hold_idx", 32'(gnt_idx), 5);
         check("hold_no_to", 32'(timeout), 0);
         cyc(1);
      end
      check("to_pulse", 32'(timeout), 1);
      check("to_valid", 32'(gnt_valid), 0);
      cyc(1);
      check("to_regrant", 32'(gnt_idx), 5);
      check("to_pulse_end", 32'(timeout), 0);
      req = 0;
      cyc(2);
      req = 16'h0080;
      cyc(1);
      check("fair_7", 32'(gnt_idx), 7);
      req = 16'h0180;
      rel = 1;
      cyc(1);
      rel = 0;
      cyc(1);
      check("fair_8", 32'(gnt_idx), 8);
      rel = 1;
      cyc(1);
      rel = 0;
      cyc(1);
      check("fair_7_again", 32'(gnt_idx), 7);
      req = 0;
      en = 0;
      cyc(2);
      req = 16'h0010;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         check("en_block_valid", 32'(gnt_valid), 0);
         check("en_block_idx", 32'(gnt_idx), 32'h0F0);
      end
      en = 1;
      cyc(1);
      check("en_grant", 32'(gnt_idx), 4);
      en = 0;
      cyc(3);
      check("en_low_hold", 32'(gnt_valid), 1);
      check("en_low_idx", 32'(gnt_idx), 4);
      req = 0;
      en = 1;
      cyc(2);
      req = 16'h0200;
      cyc(1);
      check("pre_rst_idx", 32'(gnt_idx), 9);
      rst = 1;
      cyc(1);
      check("mid_rst_valid", 32'(gnt_valid), 0);
      check("mid_rst_idx", 32'(gnt_idx), 32'h0F0);
      check("mid_rst_to", 32'(timeout), 0);
      rst = 0;
      req = 16'h0201;
      cyc(1);
      check("post_rst_idx", 32'(gnt_idx), 9);
      req = 0;
      cyc(2);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) < 3) req = N'($urandom & $urandom & $urandom);
         en = $urandom_range(0, 9) != 0;
         rel = $urandom_range(0, 9) == 0;
         rst = $urandom_range(0, 199) == 0;
         cyc(1);
      end
      rst = 0;
      rel = 0;
      cyc(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
